// File: rtl/inst_prefetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : inst_prefetch_queue
//  Description : Instruction prefetch buffer between the instruction memory
//                port and the IF/ID register. Issues sequential word fetches
//                ahead of the core, queues returned words with their PC, and
//                flushes/restarts on a taken-branch redirect.
//                Optional build macro IPQ_BYPASS_EN: when the queue is empty,
//                a live memory response is forwarded straight to fetch_*.
//  Revision    : 1.0 - initial release
// ============================================================================
module inst_prefetch_queue #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic        clock,
   input  logic        reset,
   output logic        imem_req_valid,
   output logic [31:0] imem_req_addr,
   input  logic        imem_req_ready,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   output logic        fetch_valid,
   output logic [31:0] fetch_ir,
   output logic [31:0] fetch_pc,
   output logic [31:0] fetch_pcplus4,
   input  logic        fetch_ready,
   input  logic        redirect,
   input  logic [31:0] redirect_pc
);

   localparam int c_AW = $clog2(DEPTH);
   localparam int c_CW = c_AW + 1;
   localparam logic [c_CW-1:0] c_DEPTH_CNT = c_CW'(DEPTH);
   localparam logic [c_CW:0]   c_DEPTH_SUM = (c_CW + 1)'(DEPTH);
   localparam logic [c_AW-1:0] c_PTR_ONE   = c_AW'(1);
   localparam logic [c_CW-1:0] c_CNT_ONE   = c_CW'(1);

   // Architectural state
   logic [31:0]     r_req_pc;
   logic [c_AW-1:0] r_head;
   logic [c_AW-1:0] r_tail;
   logic [c_CW-1:0] r_count;
   logic [c_CW-1:0] r_outstanding;
   logic [c_CW-1:0] r_drop;
   logic [31:0]     r_ir_q [DEPTH];
   logic [31:0]     r_pc_q [DEPTH];

   // Derived control
   logic [c_CW-1:0] w_pend;
   logic [31:0]     w_exp_pc;
   logic [c_CW:0]   w_sum;
   logic            w_req_fire;
   logic            w_empty;
   logic            w_resp_keep;
   logic            w_resp_drop;
   logic            w_byp_take;
   logic            w_push;
   logic            w_pop;
   logic [c_CW-1:0] w_out_after_resp;

   // Live (non-dropped) requests are contiguous, so the oldest one's PC is
   // req_pc minus four per pending live request; no per-request PC FIFO needed.
   assign w_pend   = r_outstanding - r_drop;
   assign w_exp_pc = r_req_pc - {{(30 - c_CW){1'b0}}, w_pend, 2'b00};

   assign w_sum          = {1'b0, r_count} + {1'b0, r_outstanding};
   assign imem_req_valid = !reset && !redirect && (w_sum < c_DEPTH_SUM);
   assign imem_req_addr  = r_req_pc;
   assign w_req_fire     = imem_req_valid && imem_req_ready;

   assign w_empty     = (r_count == '0);
   assign w_resp_keep = imem_resp_valid && (r_drop == '0);
   assign w_resp_drop = imem_resp_valid && (r_drop != '0);

`ifdef IPQ_BYPASS_EN
   logic w_byp;
   assign w_byp      = w_empty && w_resp_keep && !redirect;
   assign w_byp_take = w_byp && fetch_ready;

   // Head presentation, with an empty queue forwarding a live response
   always_comb begin
      fetch_valid = 1'b0;
      fetch_ir    = 32'h0;
      fetch_pc    = w_exp_pc;
      if (!w_empty) begin
         fetch_valid = 1'b1;
         fetch_ir    = r_ir_q[r_head];
         fetch_pc    = r_pc_q[r_head];
      end else if (w_byp) begin
         fetch_valid = 1'b1;
         fetch_ir    = imem_resp_data;
      end
   end
`else
   assign w_byp_take = 1'b0;

   // Head presentation; an empty queue shows a nop at the next expected PC
   always_comb begin
      fetch_valid = 1'b0;
      fetch_ir    = 32'h0;
      fetch_pc    = w_exp_pc;
      if (!w_empty) begin
         fetch_valid = 1'b1;
         fetch_ir    = r_ir_q[r_head];
         fetch_pc    = r_pc_q[r_head];
      end
   end
`endif

   assign fetch_pcplus4 = fetch_pc + 32'd4;

   assign w_push           = w_resp_keep && !w_byp_take;
   assign w_pop            = fetch_ready && !w_empty;
   assign w_out_after_resp = r_outstanding - c_CW'(imem_resp_valid);

   // Pointer, counter and fetch-address update; redirect overrides all else
   always_ff @(negedge clock) begin
      if (reset) begin
         r_req_pc      <= RESET_PC;
         r_head        <= '0;
         r_tail        <= '0;
         r_count       <= '0;
         r_outstanding <= '0;
         r_drop        <= '0;
      end else if (redirect) begin
         // Every response still in flight belongs to the wrong path.
         r_req_pc      <= redirect_pc & 32'hFFFF_FFFC;
         r_head        <= '0;
         r_tail        <= '0;
         r_count       <= '0;
         r_outstanding <= w_out_after_resp;
         r_drop        <= w_out_after_resp;
      end else begin
         if (w_req_fire) begin
            r_req_pc <= r_req_pc + 32'd4;
         end
         r_outstanding <= r_outstanding + c_CW'(w_req_fire) - c_CW'(imem_resp_valid);
         if (w_resp_drop) begin
            r_drop <= r_drop - c_CNT_ONE;
         end
         if (w_push) begin
            r_tail <= r_tail + c_PTR_ONE;
         end
         if (w_pop) begin
            r_head <= r_head + c_PTR_ONE;
         end
         r_count <= r_count + c_CW'(w_push) - c_CW'(w_pop);
      end
   end

   // Queue storage write at the tail
   always_ff @(negedge clock) begin
      if (!reset && !redirect && w_push) begin
         r_ir_q[r_tail] <= imem_resp_data;
         r_pc_q[r_tail] <= w_exp_pc;
      end
   end

   // The request throttle must keep every response landing in a free slot
   a_no_overflow : assert property (@(negedge clock) disable iff (reset)
      !(w_push && !redirect && !w_pop && (r_count == c_DEPTH_CNT)));

endmodule
`default_nettype wire
